// File: rtl/vga_line_fetch.sv
// rtl/vga_line_fetch.sv - VGA scanline prefetch from a shared single-port NES frame buffer
// Ping-pong line buffer filled one NES row ahead of display, arbitrated against PPU writes.
module vga_line_fetch #(
  parameter logic [10:0] X_OFF   = 11'd64,
  parameter int          FB_ROWS = 240
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [10:0] DrawX,
  input  logic [10:0] DrawY,
  input  logic        ppu_we,
  input  logic [15:0] ppu_addr,
  input  logic [5:0]  ppu_wdata,
  output logic        ppu_ready,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [5:0]  mem_wdata,
  input  logic [5:0]  mem_rdata,
  output logic [5:0]  pix_idx,
  output logic        fetch_err
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t      state, state_n;
  logic [7:0]  row, col, rd_col, trig_row;
  logic [10:0] trig_row_w, rel;
  logic        rd_pend, rd_bank, toggle;
  logic [15:0] addr_q;
  logic        trig_odd, trig_wrap, trigger;
  logic        fetch_req, ppu_req, grant_fetch, grant_ppu, visible;
  logic [5:0]  pix_rd;
  logic [5:0]  linebuf [2][256];

  // Row r is fetched on VGA line 2r-1 so it is ready for lines 2r and 2r+1.
  assign trig_row_w = (DrawY + 11'd1) >> 1;
  assign trig_odd   = DrawY[0] && (DrawY <= 11'd477);
  assign trig_wrap  = (DrawY == 11'd524);
  assign trigger    = (DrawX == 11'd0) && (trig_wrap || (trig_odd && (trig_row_w < 11'(FB_ROWS))));
  assign trig_row   = trig_wrap ? 8'd0 : trig_row_w[7:0];

  assign fetch_req  = Reset && (state == FETCH);
  assign ppu_req    = Reset && ppu_we;

  assign rel        = DrawX - X_OFF;
  assign visible    = (DrawX >= X_OFF) && (rel < 11'd512) && (DrawY < 11'd480);
  assign pix_rd     = linebuf[DrawY[1]][rel[8:1]];

  always_comb begin
    state_n     = state;
    grant_fetch = 1'b0;
    grant_ppu   = 1'b0;
    if (fetch_req && (!ppu_req || !toggle)) begin
      grant_fetch = 1'b1;
    end else if (ppu_req) begin
      grant_ppu = 1'b1;
    end

    case (state)
      IDLE:    if (trigger) state_n = FETCH;
      FETCH: begin
        if (trigger) state_n = FETCH;
        else if (grant_fetch && (col == 8'd255)) state_n = DRAIN;
      end
      DRAIN:   state_n = trigger ? FETCH : IDLE;
      default: state_n = IDLE;
    endcase

    ppu_ready = grant_ppu;
    mem_we    = grant_ppu;
    mem_wdata = grant_ppu ? ppu_wdata : 6'd0;
    if (grant_fetch)    mem_addr = {row, col};
    else if (grant_ppu) mem_addr = ppu_addr;
    else                mem_addr = addr_q;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      row       <= 8'd0;
      col       <= 8'd0;
      toggle    <= 1'b0;
      rd_pend   <= 1'b0;
      rd_col    <= 8'd0;
      rd_bank   <= 1'b0;
      addr_q    <= 16'd0;
      fetch_err <= 1'b0;
      pix_idx   <= 6'd0;
    end else begin
      state   <= state_n;
      addr_q  <= mem_addr;
      rd_pend <= grant_fetch;
      rd_col  <= col;
      rd_bank <= row[0];
      pix_idx <= visible ? pix_rd : 6'd0;
      if (trigger && (state != IDLE)) fetch_err <= 1'b1;
      // A new trigger always restarts cleanly with the fetch winning the first contest.
      if (trigger) begin
        row    <= trig_row;
        col    <= 8'd0;
        toggle <= 1'b0;
      end else begin
        if (grant_fetch) col <= col + 8'd1;
        if (fetch_req && ppu_req) toggle <= ~toggle;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (rd_pend) linebuf[rd_bank][rd_col] <= mem_rdata;
  end

endmodule

// File: doc/vga_line_fetch.md
VGA_LINE_FETCH -- requirements
Module: vga_line_fetch

Interface
REQ-001 Parameter X_OFF, default 11'd64: first VGA column of the 512-pixel doubled NES image.
REQ-002 Parameter FB_ROWS, default 240: number of NES frame-buffer rows.
REQ-003 Clk  in  1  pixel clock; the single clock of the block.
REQ-004 Reset  in  1  asynchronous, active-low reset.
REQ-005 DrawX  in  11  VGA horizontal counter, 0..799, advances once per Clk.
REQ-006 DrawY  in  11  VGA vertical counter, 0..524.
REQ-007 ppu_we  in  1  PPU frame-buffer write request.
REQ-008 ppu_addr  in  16  PPU write address, row*256+col.
REQ-009 ppu_wdata  in  6  PPU palette-index data.
REQ-010 ppu_ready  out  1  PPU write accepted this cycle.
REQ-011 mem_addr  out  16  single-port frame-buffer address.
REQ-012 mem_we  out  1  frame-buffer write enable.
REQ-013 mem_wdata  out  6  frame-buffer write data.
REQ-014 mem_rdata  in  6  read data, valid exactly 1 cycle after a read address is presented.
REQ-015 pix_idx  out  6  palette index for the VGA pixel, registered.
REQ-016 fetch_err  out  1  sticky flag: a line fetch was overrun.

Function
REQ-017 Block shall hold a ping-pong line buffer of 2 banks x 256 x 6 bits; bank = NES row bit 0.
REQ-018 Fetch trigger: at DrawX==0, DrawY odd, DrawY<=477 -> fetch row (DrawY+1)>>1; at DrawX==0, DrawY==524 -> fetch row 0.
REQ-019 FSM states IDLE, FETCH, DRAIN; IDLE->FETCH on trigger; FETCH->DRAIN once column 255 read is issued; DRAIN->IDLE one cycle later.
REQ-020 In FETCH, every granted read shall present mem_addr = row*256+col, with mem_we=0; col counts 0..255 and increments only on grant.
REQ-021 mem_rdata shall be written to line buffer [bank][col] one cycle after its address was presented, including during DRAIN.
REQ-022 Arbitration: the fetch shall be granted if only the fetch requests, and the PPU if only the PPU requests.
REQ-023 When the fetch and the PPU both request, the grant shall alternate, starting with the fetch and toggling after each contested grant.
REQ-024 PPU grant: ppu_ready=1 combinationally; the same cycle drives mem_we=1, mem_addr=ppu_addr and mem_wdata=ppu_wdata.
REQ-025 With no grant, mem_we shall be 0 and mem_addr shall hold its previous value.
REQ-026 A trigger arriving in FETCH or DRAIN shall set fetch_err, abort the current fetch and restart at col 0 for the new row.
REQ-027 A PPU write to a row currently being fetched is not ordered against the fetch; the old or new value may be captured.
REQ-028 pix_idx (1-cycle latency) shall be linebuf[(DrawY>>1)&1][(DrawX-X_OFF)>>1] when X_OFF<=DrawX<X_OFF+512 and DrawY<480, else 0.
REQ-029 Worst-case fetch time is 512 cycles (full alternation) against an 800-cycle window; fetch_err shall not set under legal VGA timing.

Reset
REQ-030 While Reset=0: FSM=IDLE, col=0, arbitration toggle=fetch-first, pix_idx=0, fetch_err=0, mem_we=0, mem_addr=0, ppu_ready=0.
REQ-031 Line-buffer contents are not reset; first-frame pixels before row 0 is fetched are undefined.
REQ-032 Reset asserted mid-fetch shall abandon the fetch; after release, no fetch starts until the next trigger.

Verification
REQ-033 Idle PPU, DrawY 524->0 -> FETCH at DrawX 0 with mem_addr 0..255 on consecutive cycles; IDLE after 257 cycles; bank 0 holds row 0.
REQ-034 ppu_we held high during fetch of row 5 -> grants alternate fetch/PPU; fetch completes in 512 cycles; mem_addr runs 1280..1535 on fetch cycles.
REQ-035 Fetched row of values 0..255 mod 64, DrawY=0 -> pix_idx at DrawX 64,65 = 0, at 66,67 = 1; DrawX 63 and 576 -> 0.
REQ-036 Forced trigger 100 cycles into a fetch -> fetch_err=1, col restarts at 0; fetch_err stays 1 until Reset.
REQ-037 Reset pulsed low mid-FETCH -> all outputs at reset values immediately; ppu_ready tracks ppu_we with no fetch until the next trigger.
REQ-038 Full 525-line frame with random PPU writes -> fetch_err=0, 240 fetches, every visible pixel matches the frame-buffer model.
